// File: rtl/cam_capture_ctrl_if.sv
// Control, camera-timing and status bundle between the top level and the frame-capture sequencer.
// slave is the sequencer side; master is whoever drives the requests and camera pins.
interface cam_capture_ctrl_if #(
    parameter int PW = 8,
    parameter int LW = 7
);
    logic          start;
    logic          stop;
    logic          mode_cont;
    logic          CAM_vsync;
    logic          CAM_href;
    logic          px_wr;
    logic          cap_en;
    logic          addr_clr;
    logic          busy;
    logic          frame_done;
    logic          frame_err;
    logic [LW-1:0] line_cnt;
    logic [PW-1:0] px_cnt;
    logic [7:0]    frame_num;

    modport slave (
        input  start, stop, mode_cont, CAM_vsync, CAM_href, px_wr,
        output cap_en, addr_clr, busy, frame_done, frame_err, line_cnt, px_cnt, frame_num
    );

    modport master (
        output start, stop, mode_cont, CAM_vsync, CAM_href, px_wr,
        input  cap_en, addr_clr, busy, frame_done, frame_err, line_cnt, px_cnt, frame_num
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: arms on start, captures whole frames between vsync edges, checks geometry.
// cap_en rises SYNC_STAGES+1 clk after the vsync fall at the pin; no backpressure, stop aborts at once.
module cam_capture_ctrl #(
    parameter int H_PIX       = 160,
    parameter int V_LINES     = 120,
    parameter int SYNC_STAGES = 2,
    parameter int PW          = $clog2(H_PIX + 1),
    parameter int LW          = $clog2(V_LINES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    cam_capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_SOF, S_CAPTURE, S_END} state_t;

    localparam logic [PW-1:0] PX_MAX = PW'(H_PIX);
    localparam logic [LW-1:0] LN_MAX = LW'(V_LINES);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] vs_sync, hr_sync;
    logic                   vs_d, hr_d;
    logic                   vs_rise, vs_fall, hr_fall;
    logic                   mode_lat, mode_nxt;
    logic                   cap_en, cap_nxt;
    logic                   addr_clr, clr_nxt;
    logic                   frame_done, done_nxt;
    logic                   frame_err, ferr_nxt;
    logic                   err_px, epx_nxt;
    logic                   err_line, eln_nxt;
    logic                   err_over, eov_nxt;
    logic [LW-1:0]          line_cnt, line_nxt;
    logic [PW-1:0]          px_cnt, px_nxt;
    logic [7:0]             frame_num, fnum_nxt;

    // vsync and href share the same depth so line and frame edges stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_sync <= '0;
            hr_sync <= '0;
            vs_d    <= 1'b0;
            hr_d    <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[SYNC_STAGES-2:0], bus.CAM_vsync};
            hr_sync <= {hr_sync[SYNC_STAGES-2:0], bus.CAM_href};
            vs_d    <= vs_sync[SYNC_STAGES-1];
            hr_d    <= hr_sync[SYNC_STAGES-1];
        end
    end

    assign vs_rise = vs_sync[SYNC_STAGES-1] & ~vs_d;
    assign vs_fall = ~vs_sync[SYNC_STAGES-1] & vs_d;
    assign hr_fall = ~hr_sync[SYNC_STAGES-1] & hr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            mode_lat   <= 1'b0;
            cap_en     <= 1'b0;
            addr_clr   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_px     <= 1'b0;
            err_line   <= 1'b0;
            err_over   <= 1'b0;
            line_cnt   <= '0;
            px_cnt     <= '0;
            frame_num  <= '0;
        end else begin
            state      <= state_nxt;
            mode_lat   <= mode_nxt;
            cap_en     <= cap_nxt;
            addr_clr   <= clr_nxt;
            frame_done <= done_nxt;
            frame_err  <= ferr_nxt;
            err_px     <= epx_nxt;
            err_line   <= eln_nxt;
            err_over   <= eov_nxt;
            line_cnt   <= line_nxt;
            px_cnt     <= px_nxt;
            frame_num  <= fnum_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_lat;
        cap_nxt   = cap_en;
        clr_nxt   = 1'b0;
        done_nxt  = 1'b0;
        ferr_nxt  = frame_err;
        epx_nxt   = err_px;
        eln_nxt   = err_line;
        eov_nxt   = err_over;
        line_nxt  = line_cnt;
        px_nxt    = px_cnt;
        fnum_nxt  = frame_num;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_ARM;
                    mode_nxt  = bus.mode_cont;
                end
            end
            // a vsync rise first guarantees we never join a frame already in progress
            S_ARM: begin
                if (vs_rise) state_nxt = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (vs_fall) begin
                    state_nxt = S_CAPTURE;
                    clr_nxt   = 1'b1;
                    cap_nxt   = 1'b1;
                    line_nxt  = '0;
                    px_nxt    = '0;
                    epx_nxt   = 1'b0;
                    eln_nxt   = 1'b0;
                    eov_nxt   = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (bus.px_wr) begin
                    if (px_cnt == PX_MAX) epx_nxt = 1'b1;
                    else                  px_nxt  = px_cnt + PW'(1);
                end
                // line check sees the pixel counted in this same cycle
                if (hr_fall) begin
                    if (px_nxt != PX_MAX) eln_nxt = 1'b1;
                    px_nxt = '0;
                    if (line_cnt == LN_MAX) eov_nxt  = 1'b1;
                    else                    line_nxt = line_cnt + LW'(1);
                end
                if (vs_rise) begin
                    state_nxt = S_END;
                    cap_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    ferr_nxt  = epx_nxt | eln_nxt | eov_nxt | (line_nxt != LN_MAX);
                    fnum_nxt  = frame_num + 8'd1;
                end
            end
            S_END: begin
                state_nxt = mode_lat ? S_WAIT_SOF : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.stop) begin
            state_nxt = S_IDLE;
            cap_nxt   = 1'b0;
            clr_nxt   = 1'b0;
            done_nxt  = 1'b0;
            ferr_nxt  = frame_err;
            fnum_nxt  = frame_num;
            line_nxt  = line_cnt;
            px_nxt    = px_cnt;
        end
    end

    assign bus.cap_en     = cap_en;
    assign bus.addr_clr   = addr_clr;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = frame_done;
    assign bus.frame_err  = frame_err;
    assign bus.line_cnt   = line_cnt;
    assign bus.px_cnt     = px_cnt;
    assign bus.frame_num  = frame_num;
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Frame-capture sequencer for the OV7670 capture path in test_cam; runs in the clk domain.
- Arms on a request, waits for a clean frame boundary on CAM_vsync, then enables the pixel-capture datapath for one frame (single-shot) or for every frame (continuous).
- Counts lines and pixels against the 160x120 frame geometry and reports done/error status to the top level and the VGA side.

Parameters:
- H_PIX, 160, pixels per active line (one px_wr pulse per 2-byte RGB pixel).
- V_LINES, 120, active lines per frame.
- SYNC_STAGES, 2, flip-flop stages on CAM_vsync/CAM_href (min 2).
- PW, $clog2(H_PIX+1), pixel counter width (8 at default).
- LW, $clog2(V_LINES+1), line counter width (7 at default).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  capture request, level-sampled each clk.
- stop  in  1  abort; highest priority.
- mode_cont  in  1  0 = single frame, 1 = continuous; sampled when leaving IDLE.
- CAM_vsync  in  1  raw camera vsync; high = vertical blanking.
- CAM_href  in  1  raw camera href; high = active line bytes.
- px_wr  in  1  one-clk pulse from the capture datapath per completed pixel; already in the clk domain.
- cap_en  out  1  capture datapath write enable.
- addr_clr  out  1  one-clk pulse that clears the buffer write address.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-clk pulse at end of a captured frame.
- frame_err  out  1  valid with frame_done; held until the next frame_done.
- line_cnt  out  LW  completed lines in the current/last frame.
- px_cnt  out  PW  pixels in the current line.
- frame_num  out  8  captured-frame counter; wraps 255->0.

Behaviour:
- Reset (rst=0, async): state IDLE; cap_en=0, addr_clr=0, busy=0, frame_done=0, frame_err=0, line_cnt=0, px_cnt=0, frame_num=0; sync chains cleared to 0.
- Sync: CAM_vsync and CAM_href each pass through SYNC_STAGES FFs plus one edge register; both get identical latency. vs_rise, vs_fall and hr_fall are one-clk pulses.
- IDLE: start=1 -> ARM.
- ARM: wait for vs_rise -> WAIT_SOF. This guarantees no partial frame is captured when start arrives mid-frame.
- WAIT_SOF: on vs_fall -> CAPTURE, with these registered effects in the same transition:
  - addr_clr=1 for exactly one cycle;
  - cap_en=1;
  - line_cnt=0, px_cnt=0, error flags cleared.
- Latency: cap_en rises SYNC_STAGES+1 clk after the CAM_vsync falling edge at the pin.
- CAPTURE:
  - px_wr: px_cnt+1, saturating at H_PIX. A px_wr while px_cnt==H_PIX sets err_px.
  - hr_fall: if px_cnt!=H_PIX, set err_line. Then px_cnt=0 and line_cnt+1, saturating at V_LINES. An hr_fall while line_cnt==V_LINES sets err_over.
  - px_wr and hr_fall in the same cycle: count the pixel first, then run the line check with the incremented value.
  - vs_rise -> END.
- END (1 cycle):
  - frame_done=1;
  - frame_err = err_px | err_line | err_over | (line_cnt!=V_LINES);
  - frame_num+1;
  - cap_en=0.
  - Next state: WAIT_SOF if the latched mode_cont=1 and stop=0; otherwise IDLE.
  - line_cnt holds its final value until the next capture begins.
- stop=1 in any state: next state IDLE, cap_en=0 on the next edge, no frame_done, frame_num unchanged. stop overrides start in the same cycle.
- start pulses while busy=1 are ignored.
- mode_cont changes while busy affect nothing until the next IDLE exit.
- Async reset mid-CAPTURE: immediate return to the reset values; no frame_done.

Test Plan:
- Single shot: camera model at pclk=clk/4 with 320 bytes/line, 120 lines and 4 blank lines (px_wr every 8 clk). Assert start mid-frame -> no capture in the current frame; cap_en rises 3 clk after the next vsync fall; one addr_clr pulse; frame_done with frame_err=0, line_cnt=120, frame_num=1; then IDLE, busy=0.
- Continuous: mode_cont=1, run 3 frames -> 3 frame_done pulses, frame_num=3, cap_en low only between vs_rise and the next vs_fall. Assert stop -> IDLE within 1 clk, cap_en=0, frame_num stays 3.
- Short line: drop 1 px_wr on line 10 -> frame_err=1 at frame_done; line_cnt=120.
- Extra lines: model with 122 active lines -> line_cnt saturates at 120, err_over set, frame_err=1.
- Simultaneous px_wr and href fall on the 160th pixel -> no err_line, px_cnt=0, line_cnt increments.
- rst pulsed low for 1 clk during line 50 -> all outputs return to reset values asynchronously; the next start captures a clean frame with frame_num=1.
